// File: rtl/butterfly_operand_router.sv
// Routes two LANES-wide coefficient read words into per-butterfly TOP/BOTTOM operands,
// behind a valid/ready skid buffer. Optional perf counters: BUTTERFLY_ROUTER_PERF_EN.
module butterfly_operand_router #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LANES    = 4,
    parameter int unsigned STRIDE_W = 10
) (
    input  logic                      i_CLK,
    input  logic                      i_RESET,
    input  logic                      i_VALID,
    output logic                      o_READY,
    input  logic [STRIDE_W-1:0]       i_STRIDE,
    input  logic [LANES*DATA_W-1:0]   i_READ_OUTPUT1,
    input  logic [LANES*DATA_W-1:0]   i_READ_OUTPUT2,
    output logic                      o_VALID,
    input  logic                      i_READY,
    output logic [LANES*DATA_W-1:0]   o_TOP,
    output logic [LANES*DATA_W-1:0]   o_BOTTOM,
    output logic                      o_STRIDE_ERR
`ifdef BUTTERFLY_ROUTER_PERF_EN
    ,
    output logic [31:0]               o_XFER_CNT,
    output logic [31:0]               o_STALL_CNT
`endif
);

    localparam int unsigned LOG_L  = $clog2(LANES);
    localparam int unsigned WORD_W = LANES * DATA_W;

    logic [2*WORD_W-1:0] elems_c;
    logic [WORD_W-1:0]   rt_top_c, rt_bot_c;
    logic [31:0]         stride_c;
    logic                legal_c, stride_bad_c;
    logic                accept_c, emit_c;

    logic                valid_q, valid_d;
    logic                ready_q, ready_d;
    logic                skid_full_q, skid_full_d;
    logic                err_q, err_d;
    logic [WORD_W-1:0]   top_q, top_d, bot_q, bot_d;
    logic [WORD_W-1:0]   skid_top_q, skid_top_d, skid_bot_q, skid_bot_d;

    assign elems_c  = {i_READ_OUTPUT2, i_READ_OUTPUT1};
    assign stride_c = 32'(i_STRIDE);

    // Operand routing for the incoming beat; strides 1..L/2 select grouped pairs, anything else is straight.
    always_comb begin
        rt_top_c = i_READ_OUTPUT1;
        rt_bot_c = i_READ_OUTPUT2;
        legal_c  = 1'b0;
        for (int unsigned j = 0; j < LOG_L; j++) begin
            if (stride_c == (32'd1 << j)) begin
                legal_c = 1'b1;
                for (int unsigned k = 0; k < LANES; k++) begin
                    rt_top_c[k*DATA_W +: DATA_W] =
                        elems_c[(((k >> j) << (j + 1)) + (k & ((32'd1 << j) - 1))) * DATA_W +: DATA_W];
                    rt_bot_c[k*DATA_W +: DATA_W] =
                        elems_c[(((k >> j) << (j + 1)) + (k & ((32'd1 << j) - 1)) + (32'd1 << j)) * DATA_W +: DATA_W];
                end
            end
        end
        stride_bad_c = (stride_c == 32'd0) || ((stride_c < LANES) && !legal_c);
    end

    assign accept_c = i_VALID & ready_q;
    assign emit_c   = valid_q & i_READY;

    // Two-entry FIFO: main register feeds the outputs, skid catches one beat under back-pressure.
    always_comb begin
        valid_d     = valid_q;
        skid_full_d = skid_full_q;
        top_d       = top_q;
        bot_d       = bot_q;
        skid_top_d  = skid_top_q;
        skid_bot_d  = skid_bot_q;
        err_d       = err_q | (accept_c & stride_bad_c);
        if (skid_full_q) begin
            if (emit_c) begin
                top_d       = skid_top_q;
                bot_d       = skid_bot_q;
                skid_full_d = 1'b0;
            end
        end else if (accept_c) begin
            if (!valid_q || emit_c) begin
                top_d   = rt_top_c;
                bot_d   = rt_bot_c;
                valid_d = 1'b1;
            end else begin
                skid_top_d  = rt_top_c;
                skid_bot_d  = rt_bot_c;
                skid_full_d = 1'b1;
            end
        end else if (emit_c) begin
            valid_d = 1'b0;
        end
        ready_d = !skid_full_d;
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            valid_q     <= 1'b0;
            ready_q     <= 1'b1;
            skid_full_q <= 1'b0;
            err_q       <= 1'b0;
            top_q       <= '0;
            bot_q       <= '0;
            skid_top_q  <= '0;
            skid_bot_q  <= '0;
        end else begin
            valid_q     <= valid_d;
            ready_q     <= ready_d;
            skid_full_q <= skid_full_d;
            err_q       <= err_d;
            top_q       <= top_d;
            bot_q       <= bot_d;
            skid_top_q  <= skid_top_d;
            skid_bot_q  <= skid_bot_d;
        end
    end

    assign o_VALID      = valid_q;
    assign o_READY      = ready_q;
    assign o_TOP        = top_q;
    assign o_BOTTOM     = bot_q;
    assign o_STRIDE_ERR = err_q;

`ifdef BUTTERFLY_ROUTER_PERF_EN
    logic [31:0] xfer_cnt_q, xfer_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        xfer_cnt_d  = xfer_cnt_q + 32'(emit_c);
        stall_cnt_d = stall_cnt_q + 32'(valid_q & ~i_READY);
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            xfer_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            xfer_cnt_q  <= xfer_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_XFER_CNT  = xfer_cnt_q;
    assign o_STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_butterfly_operand_router.sv
// Bench for butterfly_operand_router: directed mapping cases, back-pressure stream,
// mid-stream reset and random traffic against a queue-based reference model.
module tb_butterfly_operand_router;

    localparam int unsigned DW = 32;
    localparam int unsigned L  = 4;
    localparam int unsigned SW = 10;
    localparam int unsigned WW = L * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vin = 1'b0;
    logic          rrdy = 1'b1;
    logic [SW-1:0] stride = '0;
    logic [WW-1:0] rd1 = '0, rd2 = '0;
    logic          o_ready, o_valid, o_err;
    logic [WW-1:0] o_top, o_bot;
`ifdef BUTTERFLY_ROUTER_PERF_EN
    logic [31:0]   o_xfer, o_stall;
`endif

    butterfly_operand_router #(.DATA_W(DW), .LANES(L), .STRIDE_W(SW)) dut (
        .i_CLK(clk), .i_RESET(rst), .i_VALID(vin), .o_READY(o_ready),
        .i_STRIDE(stride), .i_READ_OUTPUT1(rd1), .i_READ_OUTPUT2(rd2),
        .o_VALID(o_valid), .i_READY(rrdy), .o_TOP(o_top), .o_BOTTOM(o_bot),
        .o_STRIDE_ERR(o_err)
`ifdef BUTTERFLY_ROUTER_PERF_EN
        , .o_XFER_CNT(o_xfer), .o_STALL_CNT(o_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WW-1:0] q_top[$];
    logic [WW-1:0] q_bot[$];
    logic          err_m = 1'b0;
    int unsigned   xfer_m = 0, stall_m = 0;
    bit            acc_last;
    int            n_emit_dut = 0;

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference mapping straight from the element-view rules.
    function automatic void route(input logic [WW-1:0] a, input logic [WW-1:0] b, input int unsigned s,
                                  output logic [WW-1:0] t, output logic [WW-1:0] bo, output bit bad);
        logic [DW-1:0] e[2*L];
        bit legal;
        for (int i = 0; i < L; i++) begin
            e[i]     = a[i*DW +: DW];
            e[i + L] = b[i*DW +: DW];
        end
        legal = (s >= 1) && (s < L) && ((s & (s - 1)) == 0);
        bad   = (s == 0) || ((s < L) && !legal);
        for (int k = 0; k < L; k++) begin
            if (legal) begin
                t[k*DW +: DW]  = e[2*s*(k/s) + k%s];
                bo[k*DW +: DW] = e[2*s*(k/s) + k%s + s];
            end else begin
                t[k*DW +: DW]  = e[k];
                bo[k*DW +: DW] = e[k + L];
            end
        end
    endfunction

    // One clock: model advances with the inputs seen at the edge, then outputs are compared.
    task automatic tick();
        logic [WW-1:0] t, b;
        bit bad, emit, acc;
        if (o_valid && rrdy) n_emit_dut++;
        @(posedge clk);
        acc = 1'b0;
        if (rst) begin
            q_top.delete(); q_bot.delete();
            err_m = 1'b0; xfer_m = 0; stall_m = 0;
        end else begin
            emit = (q_top.size() > 0) && rrdy;
            acc  = vin && (q_top.size() < 2);
            if (q_top.size() > 0 && !rrdy) stall_m++;
            if (emit) begin
                void'(q_top.pop_front()); void'(q_bot.pop_front());
                xfer_m++;
            end
            if (acc) begin
                route(rd1, rd2, int'(stride), t, b, bad);
                q_top.push_back(t); q_bot.push_back(b);
                if (bad) err_m = 1'b1;
            end
        end
        acc_last = acc;
        #1;
        chk("o_VALID", WW'(o_valid), WW'(q_top.size() > 0));
        chk("o_READY", WW'(o_ready), WW'(q_top.size() < 2));
        chk("o_STRIDE_ERR", WW'(o_err), WW'(err_m));
        if (rst) begin
            chk("reset_top", o_top, '0);
            chk("reset_bottom", o_bot, '0);
        end else if (q_top.size() > 0) begin
            chk("o_TOP", o_top, q_top[0]);
            chk("o_BOTTOM", o_bot, q_bot[0]);
        end
`ifdef BUTTERFLY_ROUTER_PERF_EN
        chk("o_XFER_CNT", WW'(o_xfer), WW'(xfer_m));
        chk("o_STALL_CNT", WW'(o_stall), WW'(stall_m));
`endif
    endtask

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] w;
        for (int i = 0; i < L; i++) w[i*DW +: DW] = $urandom;
        return w;
    endfunction

    task automatic single_beat(input int unsigned s, input logic [WW-1:0] et, input logic [WW-1:0] eb,
                               input string tag);
        vin = 1'b1; stride = SW'(s); rrdy = 1'b1;
        tick();
        vin = 1'b0;
        chk({tag, "_valid"}, WW'(o_valid), WW'(1));
        chk({tag, "_top"}, o_top, et);
        chk({tag, "_bot"}, o_bot, eb);
        tick();
    endtask

    initial begin
        int unsigned strides[6];
        int bi, cyc;
        strides = '{1, 2, 4, 1, 2, 4};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        rd1 = {32'd3, 32'd2, 32'd1, 32'd0};
        rd2 = {32'd7, 32'd6, 32'd5, 32'd4};
        single_beat(8, {32'd3, 32'd2, 32'd1, 32'd0}, {32'd7, 32'd6, 32'd5, 32'd4}, "s8");
        chk("s8_no_err", WW'(o_err), WW'(0));
        single_beat(2, {32'd5, 32'd4, 32'd1, 32'd0}, {32'd7, 32'd6, 32'd3, 32'd2}, "s2");
        single_beat(1, {32'd6, 32'd4, 32'd2, 32'd0}, {32'd7, 32'd5, 32'd3, 32'd1}, "s1");
        single_beat(3, {32'd3, 32'd2, 32'd1, 32'd0}, {32'd7, 32'd6, 32'd5, 32'd4}, "s3");
        chk("s3_err", WW'(o_err), WW'(1));
        single_beat(2, {32'd5, 32'd4, 32'd1, 32'd0}, {32'd7, 32'd6, 32'd3, 32'd2}, "s2_after_err");
        chk("err_sticky", WW'(o_err), WW'(1));
        single_beat(0, {32'd3, 32'd2, 32'd1, 32'd0}, {32'd7, 32'd6, 32'd5, 32'd4}, "s0");

        // Six-beat stream with a three-cycle back-pressure window.
        rst = 1'b1; tick(); rst = 1'b0;
        n_emit_dut = 0;
        bi = 0; cyc = 0;
        while (bi < 6 && cyc < 40) begin
            vin = 1'b1; stride = SW'(strides[bi]);
            rd1 = rand_word(); rd2 = rand_word();
            rrdy = !(cyc >= 2 && cyc < 5);
            tick();
            if (acc_last) bi++;
            cyc++;
        end
        chk("stream_accepted", WW'(bi), WW'(6));
        vin = 1'b0; rrdy = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("stream_emitted", WW'(n_emit_dut), WW'(6));

        // Fill both registers, then reset: stored beats must vanish.
        vin = 1'b1; rrdy = 1'b0; stride = SW'(3);
        for (int i = 0; i < 3; i++) begin
            rd1 = rand_word(); rd2 = rand_word();
            tick();
        end
        chk("skid_full_ready", WW'(o_ready), WW'(0));
        rst = 1'b1; vin = 1'b0;
        tick();
        rst = 1'b0; rrdy = 1'b1;
        chk("rst_valid", WW'(o_valid), WW'(0));
        chk("rst_ready", WW'(o_ready), WW'(1));
        chk("rst_err", WW'(o_err), WW'(0));
        for (int i = 0; i < 3; i++) tick();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            vin  = ($urandom_range(0, 3) != 0);
            rrdy = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0: stride = SW'($urandom_range(0, 9));
                1: stride = SW'(32'd1 << $urandom_range(0, 1));
                2: stride = SW'($urandom);
                default: stride = SW'(8);
            endcase
            rd1 = rand_word(); rd2 = rand_word();
            tick();
        end
        vin = 1'b0; rrdy = 1'b1;
        for (int i = 0; i < 3; i++) tick();

`ifdef BUTTERFLY_ROUTER_PERF_EN
        // Ten emits with four stalled cycles.
        rst = 1'b1; tick(); rst = 1'b0;
        bi = 0; cyc = 0;
        while (bi < 10 && cyc < 40) begin
            vin = 1'b1; stride = SW'(1);
            rd1 = rand_word(); rd2 = rand_word();
            rrdy = !(cyc >= 3 && cyc < 7);
            tick();
            if (acc_last) bi++;
            cyc++;
        end
        vin = 1'b0; rrdy = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("perf_xfer", WW'(o_xfer), WW'(10));
        chk("perf_stall", WW'(o_stall), WW'(4));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
